// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready producers into one registered output slot.
// Each output word carries the index of the requester that produced it.
module pipeline_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            s_data_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_rdata,
    output logic [NUM_REQ-1:0]            s_data_ready,
    output logic                          m_data_valid,
    input  logic                          m_data_ready,
    output logic [DATA_WIDTH-1:0]         m_data_rdata,
    output logic [ID_WIDTH-1:0]           m_data_id,
    input  logic                          s_ctrl_stall,
    input  logic                          s_ctrl_flush
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slotState_e;

    slotState_e            r_slotState;
    slotState_e            w_slotNext;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ID_WIDTH-1:0]   r_ptr;

    logic                  w_valid;
    logic                  w_anyReq;
    logic                  w_canAccept;
    logic                  w_accept;
    logic                  w_drain;
    logic [ID_WIDTH-1:0]   w_grant;
    logic [ID_WIDTH-1:0]   w_ptrNext;
    logic [DATA_WIDTH-1:0] w_payload [NUM_REQ];

    for (genvar gk = 0; gk < NUM_REQ; gk++) begin : g_payload
        assign w_payload[gk] = s_data_rdata[gk*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_valid     = (r_slotState == SLOT_FULL);
    assign w_anyReq    = |s_data_valid;
    assign w_canAccept = ~rst_i & ~s_ctrl_stall & ~s_ctrl_flush & (~w_valid | m_data_ready);
    assign w_accept    = w_canAccept & w_anyReq;
    assign w_drain     = w_valid & m_data_ready & ~s_ctrl_flush;

    // Later passes override earlier ones: the lowest index at or above r_ptr beats any index below it.
    always_comb begin
        w_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (s_data_valid[k] && (k < int'(r_ptr))) begin
                w_grant = ID_WIDTH'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (s_data_valid[k] && (k >= int'(r_ptr))) begin
                w_grant = ID_WIDTH'(k);
            end
        end
    end

    assign w_ptrNext = (w_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (w_grant + ID_WIDTH'(1));

    always_comb begin
        s_data_ready = '0;
        if (w_accept) begin
            s_data_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slotState <= SLOT_EMPTY;
        end else begin
            r_slotState <= w_slotNext;
        end
    end

    // Accept wins over drain so a simultaneous drain+accept reloads the slot without a bubble.
    always_comb begin
        w_slotNext = r_slotState;
        if (s_ctrl_flush) begin
            w_slotNext = SLOT_EMPTY;
        end else if (w_accept) begin
            w_slotNext = SLOT_FULL;
        end else if (w_drain) begin
            w_slotNext = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_data <= w_payload[w_grant];
            r_id   <= w_grant;
            r_ptr  <= w_ptrNext;
        end
    end

    // Flush masks the slot contents in the same cycle; the registers keep their stale values.
    always_comb begin
        m_data_valid = w_valid & ~s_ctrl_flush;
        m_data_rdata = s_ctrl_flush ? '0 : r_data;
        m_data_id    = s_ctrl_flush ? '0 : r_id;
    end

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Bench for pipeline_rr_arbiter: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a queue-free behavioural model of the arbiter and slot.
module tb_pipeline_rr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic [NR-1:0]     sValid = '0;
    logic [NR*DW-1:0]  sRdata = '0;
    logic              mReady = 1'b0;
    logic              stall  = 1'b0;
    logic              flush  = 1'b0;

    logic [NR-1:0]     sReady;
    logic              mValidOut;
    logic [DW-1:0]     mRdataOut;
    logic [IW-1:0]     mIdOut;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents and rotating priority pointer as plain integers.
    bit                mValid = 1'b0;
    logic [DW-1:0]     mData  = '0;
    int                mId    = 0;
    int                mPtr   = 0;
    int                mGrant;
    logic [NR-1:0]     mRdy;

    pipeline_rr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .ID_WIDTH  (IW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_data_valid (sValid),
        .s_data_rdata (sRdata),
        .s_data_ready (sReady),
        .m_data_valid (mValidOut),
        .m_data_ready (mReady),
        .m_data_rdata (mRdataOut),
        .m_data_id    (mIdOut),
        .s_ctrl_stall (stall),
        .s_ctrl_flush (flush)
    );

    always #5 clk = ~clk;

    function automatic int modelGrant();
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (mPtr + i) % NR;
            if (sValid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] modelReady();
        int g;
        if (rst || stall || flush || (mValid && !mReady)) return '0;
        g = modelGrant();
        if (g < 0) return '0;
        return NR'(1) << g;
    endfunction

    function automatic logic [DW-1:0] payload(input int k);
        return sRdata[k*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        sValid = '0;
        mReady = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic setDefaultPayloads();
        for (int k = 0; k < NR; k++) begin
            sRdata[k*DW +: DW] = 32'hA0 + 32'(k);
        end
    endtask

    // Model advances on the same edge as the DUT, using the inputs held stable across the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid = 1'b0;
            mData  = '0;
            mId    = 0;
            mPtr   = 0;
        end else begin
            mRdy   = modelReady();
            mGrant = modelGrant();
            if (mRdy != '0) begin
                mData  = payload(mGrant);
                mId    = mGrant;
                mValid = 1'b1;
                mPtr   = (mGrant + 1) % NR;
            end else if (flush || (mValid && mReady)) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_m_valid", 32'(mValidOut), flush ? 32'd0 : 32'(mValid));
        checkOutput("cmp_m_rdata", mRdataOut, flush ? 32'd0 : mData);
        checkOutput("cmp_m_id", 32'(mIdOut), flush ? 32'd0 : 32'(mId));
        checkOutput("cmp_s_ready", 32'(sReady), 32'(modelReady()));
    end

    task automatic applyStimulus();
        sValid = NR'($urandom);
        for (int k = 0; k < NR; k++) begin
            sRdata[k*DW +: DW] = $urandom;
        end
        mReady = ($urandom_range(0, 3) != 0);
        stall  = ($urandom_range(0, 9) == 0);
        flush  = ($urandom_range(0, 11) == 0);
        rst    = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        setDefaultPayloads();
        sValid = 4'b1111;
        mReady = 1'b1;
        step();
        step();
        checkOutput("rst_m_valid", 32'(mValidOut), 32'd0);
        checkOutput("rst_m_rdata", mRdataOut, 32'd0);
        checkOutput("rst_m_id", 32'(mIdOut), 32'd0);
        checkOutput("rst_s_ready", 32'(sReady), 32'd0);

        rst = 1'b0;
        #1;
        checkOutput("rr_first_ready", 32'(sReady), 32'b0001);
        for (int j = 0; j < 5; j++) begin
            step();
            checkOutput("rr_m_valid", 32'(mValidOut), 32'd1);
            checkOutput("rr_m_id", 32'(mIdOut), 32'(j % 4));
            checkOutput("rr_m_rdata", mRdataOut, 32'hA0 + 32'(j % 4));
            checkOutput("rr_s_ready", 32'(sReady), 32'(1 << ((j + 1) % 4)));
        end

        doReset();
        sValid = 4'b1010;
        mReady = 1'b1;
        #1;
        checkOutput("fair_first_ready", 32'(sReady), 32'b0010);
        for (int j = 0; j < 6; j++) begin
            step();
            checkOutput("fair_m_id", 32'(mIdOut), (j % 2 == 0) ? 32'd1 : 32'd3);
            checkOutput("fair_m_rdata", mRdataOut, (j % 2 == 0) ? 32'hA1 : 32'hA3);
            checkOutput("fair_s_ready", 32'(sReady), (j % 2 == 0) ? 32'b1000 : 32'b0010);
        end

        doReset();
        sValid = 4'b0001;
        mReady = 1'b0;
        #1;
        checkOutput("bp_first_ready", 32'(sReady), 32'b0001);
        step();
        sRdata[0 +: DW] = 32'hB0;
        #1;
        for (int j = 0; j < 5; j++) begin
            checkOutput("bp_hold_valid", 32'(mValidOut), 32'd1);
            checkOutput("bp_hold_rdata", mRdataOut, 32'hA0);
            checkOutput("bp_hold_ready", 32'(sReady), 32'd0);
            step();
        end
        mReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(sReady), 32'b0001);
        step();
        checkOutput("bp_nobubble_valid", 32'(mValidOut), 32'd1);
        checkOutput("bp_nobubble_rdata", mRdataOut, 32'hB0);
        setDefaultPayloads();

        doReset();
        sValid = 4'b1111;
        mReady = 1'b1;
        #1;
        step();
        checkOutput("stall_pre_id", 32'(mIdOut), 32'd0);
        stall = 1'b1;
        #1;
        checkOutput("stall_ready", 32'(sReady), 32'd0);
        checkOutput("stall_still_full", 32'(mValidOut), 32'd1);
        step();
        checkOutput("stall_drained", 32'(mValidOut), 32'd0);
        for (int j = 0; j < 3; j++) begin
            step();
            checkOutput("stall_empty_valid", 32'(mValidOut), 32'd0);
            checkOutput("stall_empty_ready", 32'(sReady), 32'd0);
        end
        stall = 1'b0;
        #1;
        checkOutput("stall_resume_ready", 32'(sReady), 32'b0010);
        step();
        checkOutput("stall_resume_id", 32'(mIdOut), 32'd1);

        doReset();
        sRdata[2*DW +: DW] = 32'hDEADBEEF;
        sValid = 4'b0100;
        mReady = 1'b0;
        #1;
        step();
        checkOutput("flush_pre_rdata", mRdataOut, 32'hDEADBEEF);
        checkOutput("flush_pre_id", 32'(mIdOut), 32'd2);
        sValid = 4'b1111;
        flush  = 1'b1;
        #1;
        checkOutput("flush_m_valid", 32'(mValidOut), 32'd0);
        checkOutput("flush_m_rdata", mRdataOut, 32'd0);
        checkOutput("flush_m_id", 32'(mIdOut), 32'd0);
        checkOutput("flush_s_ready", 32'(sReady), 32'd0);
        step();
        flush = 1'b0;
        #1;
        checkOutput("flush_after_valid", 32'(mValidOut), 32'd0);
        checkOutput("flush_after_ready", 32'(sReady), 32'b1000);
        step();
        checkOutput("flush_next_id", 32'(mIdOut), 32'd3);
        checkOutput("flush_next_rdata", mRdataOut, 32'hA3);
        setDefaultPayloads();

        doReset();
        sValid = 4'b0100;
        mReady = 1'b1;
        #1;
        step();
        sValid = 4'b0001;
        #1;
        checkOutput("wrap_ready", 32'(sReady), 32'b0001);
        step();
        checkOutput("wrap_id", 32'(mIdOut), 32'd0);
        sValid = 4'b1111;
        #1;
        checkOutput("wrap_ptr_ready", 32'(sReady), 32'b0010);
        checkOutput("wrap_full", 32'(mValidOut), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_m_valid", 32'(mValidOut), 32'd0);
        checkOutput("arst_m_rdata", mRdataOut, 32'd0);
        checkOutput("arst_s_ready", 32'(sReady), 32'd0);
        step();
        rst = 1'b0;

        doReset();
        for (int c = 0; c < 600; c++) begin
            step();
            applyStimulus();
        end
        step();
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_rr_arbiter.md
Name: pipeline_rr_arbiter

Overview:
- Shares one pipeline stage between NUM_REQ upstream producers using a round-robin arbiter with a registered output slot.
- Sits in front of a pipeline register chain wherever several sources feed one datapath, e.g. multiple table-walk requesters feeding a single lookup pipe.
- Uses the same valid/ready/rdata handshake and the same stall/flush control semantics as the team's pipeline registers.
- Tags each output word with the index of the requester that produced it.

Parameters:
- DATA_WIDTH, 32, payload width per requester.
- NUM_REQ, 4, number of requesters (≥2, not required to be a power of two).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_data_valid  in  NUM_REQ  per-requester valid.
- s_data_rdata  in  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_data_ready  out  NUM_REQ  one-hot or zero grant/ready.
- m_data_valid  out  1  output slot holds a valid word.
- m_data_ready  in  1  downstream consumer accepts.
- m_data_rdata  out  DATA_WIDTH  output payload.
- m_data_id  out  ID_WIDTH  index of the requester that produced m_data_rdata.
- s_ctrl_stall  in  1  external stall.
- s_ctrl_flush  in  1  external flush.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- State:
  - valid_q, data_q[DATA_WIDTH], id_q[ID_WIDTH].
  - ptr_q[ID_WIDTH], the highest-priority index.
  - On reset all are 0, so every output is 0 during and after reset until the first accept.
- Slot state machine, encoded by valid_q:
  - EMPTY: valid_q=0.
  - FULL: valid_q=1.
- Conditions:
  - drain = valid_q & m_data_ready & ~flush.
  - can_accept = ~s_ctrl_stall & ~s_ctrl_flush & (~valid_q | m_data_ready).
- Arbitration (combinational):
  - grant = first k with s_data_valid[k]=1, searching ptr_q, ptr_q+1, …, NUM_REQ-1, 0, …, ptr_q-1 (wrap modulo NUM_REQ).
  - any_req = |s_data_valid.
- Ready generation:
  - s_data_ready[k] = can_accept & any_req & (k == grant).
  - Ready depends combinationally on valid. Requesters must not make valid depend on ready.
- Accept (s_data_ready[grant] high at the edge):
  - data_q <= the grant payload; id_q <= grant; valid_q <= 1.
  - ptr_q <= (grant == NUM_REQ-1) ? 0 : grant+1.
- Drain without accept: valid_q <= 0; data_q and id_q hold.
- Simultaneous drain and accept: the slot reloads with no bubble, giving a sustained 1 word/cycle.
- No accept and no drain: all state holds; ptr_q holds.
- Latency: a word accepted at edge N appears on m_data_* in the cycle after edge N (1 cycle).
- Stall:
  - Blocks acceptance only: s_data_ready=0, ptr_q frozen.
  - A FULL slot still drains if m_data_ready=1.
- Flush:
  - In the flush cycle, m_data_valid, m_data_rdata and m_data_id are forced to 0 combinationally, and s_data_ready=0.
  - valid_q <= 0 at the next edge. ptr_q is unchanged. data_q and id_q hold but are masked.
- Flush and stall together: flush dominates.
- Outputs when not flushing: m_data_valid=valid_q, m_data_rdata=data_q, m_data_id=id_q.
- No request (any_req=0): no state change except drain.
- Reset asserted mid-transfer:
  - The slot is emptied and ptr_q returns to 0 immediately (asynchronous).
  - Any in-flight word is lost.

Test Plan:
- Reset: assert rst_i with all s_data_valid=1 -> all outputs 0 during reset; ptr_q=0. Release reset with m_data_ready=1 -> grants go 0,1,2,3,0 on successive cycles, m_data_id follows 1 cycle later, m_data_valid stays high.
- Fairness: NUM_REQ=4, only requesters 1 and 3 valid, payloads 0xA1/0xA3, m_data_ready=1 -> output alternates 0xA1(id1), 0xA3(id3), 0xA1…. Requester 1 never receives two consecutive grants.
- Backpressure: m_data_ready=0 after one accept -> m_data_valid=1 and data_q holds for 5 cycles, s_data_ready=0. Raise m_data_ready -> drain and new accept on the same edge, no bubble.
- Stall: slot FULL, s_ctrl_stall=1, m_data_ready=1 -> slot drains in 1 cycle, m_data_valid=0 for the rest of the stall, ptr_q unchanged. Release stall -> the next grant starts at the saved ptr_q.
- Flush: slot FULL with 0xDEADBEEF, id2; pulse s_ctrl_flush for 1 cycle with s_data_valid=4'b1111 -> that cycle m_data_valid=0, m_data_rdata=0, s_data_ready=0. Next cycle slot EMPTY. The following grant goes to requester 3, since ptr_q was left at 3 by the id2 accept.
- Wrap and async reset: ptr_q=3, only requester 0 valid -> grant 0, ptr_q becomes 1. Assert rst_i between clock edges while the slot is FULL -> m_data_valid drops to 0 before the next edge.
